// File: rtl/seq_step_fsm_pkg.sv
// Shared encodings and sizing helpers for the step sequencer.
package seq_step_fsm_pkg;

    localparam int STATE_W = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 8'd0,
        START = 8'd1,
        RUN   = 8'd2,
        END   = 8'd3
    } state_t;

    // A single-step sequencer still needs a one-bit index port.
    function automatic int stepIdxW(input int numSteps);
        return (numSteps > 1) ? $clog2(numSteps) : 1;
    endfunction

endpackage

// File: rtl/seq_step_fsm_dwell_counter.sv
// Load/decrement dwell counter; sticks at zero until reloaded.
module dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - DWELL_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/seq_step_fsm.sv
// Step sequencer: captures a seed, then adds STEP_INC once per dwell period
// for NUM_STEPS steps, optionally looping back to recapture.
//
// state | meaning
// IDLE  | waiting for start
// START | capture in1 and dwell, clear step index
// RUN   | count dwell, advance out1 on each step event
// END   | pass complete; loop_en chooses START or IDLE
module seq_step_fsm
    import seq_step_fsm_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          NUM_STEPS = 4,
    parameter int          DWELL_W   = 8,
    parameter int unsigned STEP_INC  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             loop_en,
    input  logic [DWELL_W-1:0]               dwell,
    input  logic [DATA_W-1:0]                in1,
    output logic [DATA_W-1:0]                out1,
    output logic                             out_valid,
    output logic [stepIdxW(NUM_STEPS)-1:0]   step_idx,
    output logic                             busy,
    output logic                             done,
    output logic [STATE_W-1:0]               fsm_state
);

    localparam int                IDX_W    = stepIdxW(NUM_STEPS);
    localparam logic [DATA_W-1:0] INC      = DATA_W'(STEP_INC);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_STEPS - 1);

    state_t             state;
    logic [DWELL_W-1:0] dwellLat;
    logic [DWELL_W-1:0] loadVal;
    logic               cntZero;
    logic               cntLoad;
    logic               cntEn;
    logic               stepEvt;
    logic               isLast;

    // Abort suppresses a coincident step event entirely.
    assign stepEvt = (state == RUN) && cntZero && !abort;
    assign isLast  = (step_idx == LAST_IDX);
    assign cntLoad = ((state == START) && !abort) || (stepEvt && !isLast);
    assign cntEn   = (state == RUN) && !abort;
    assign loadVal = (state == START) ? dwell : dwellLat;

    dwell_counter #(
        .DWELL_W(DWELL_W)
    ) uDwellCnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cntLoad),
        .load_val(loadVal),
        .en      (cntEn),
        .zero    (cntZero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out1      <= '0;
            out_valid <= 1'b0;
            step_idx  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dwellLat  <= '0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        out1     <= in1;
                        step_idx <= '0;
                        dwellLat <= dwell;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (stepEvt) begin
                        out1      <= out1 + INC;
                        out_valid <= 1'b1;
                        if (isLast) begin
                            state <= END;
                            done  <= 1'b1;
                        end else begin
                            step_idx <= step_idx + IDX_W'(1);
                        end
                    end
                end
                END: begin
                    if (abort || !loop_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= START;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_seq_step_fsm.sv
// Directed bench for seq_step_fsm: per-cycle vector table for a basic pass,
// hand-written sequences for wrap, loop, abort, reset and contention cases.
module tb_seq_step_fsm;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        loopEn;
    logic [7:0]  dwell;
    logic [31:0] in1;

    logic [31:0] outA;
    logic        validA;
    logic [1:0]  idxA;
    logic        busyA;
    logic        doneA;
    logic [7:0]  stA;

    logic [31:0] outB;
    logic        validB;
    logic [0:0]  idxB;
    logic        busyB;
    logic        doneB;
    logic [7:0]  stB;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    seq_step_fsm #(.DATA_W(32), .NUM_STEPS(4), .DWELL_W(8), .STEP_INC(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loopEn),
        .dwell(dwell), .in1(in1), .out1(outA), .out_valid(validA),
        .step_idx(idxA), .busy(busyA), .done(doneA), .fsm_state(stA)
    );

    seq_step_fsm #(.DATA_W(32), .NUM_STEPS(2), .DWELL_W(8), .STEP_INC(1)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loopEn),
        .dwell(dwell), .in1(in1), .out1(outB), .out_valid(validB),
        .step_idx(idxB), .busy(busyB), .done(doneB), .fsm_state(stB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int start;
        int dwell;
        int in1;
        int st;
        int o;
        int v;
        int idx;
        int b;
        int d;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tickTo(input int n);
        while (cyc < n) tick();
    endtask

    task automatic doReset;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        loopEn = 1'b0;
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int doneSeen;
        int firstValid;
        logic [31:0] mask;
        logic [31:0] expMask;

        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        loopEn = 1'b0;
        dwell  = 8'd2;
        in1    = 32'h10;

        // inputs applied during cycle i, expectations visible in cycle i+1
        tv[0]  = '{1, 2, 'h10, 1, 'h00, 0, 0, 1, 0};
        tv[1]  = '{0, 2, 'h10, 2, 'h10, 0, 0, 1, 0};
        tv[2]  = '{0, 2, 'h10, 2, 'h10, 0, 0, 1, 0};
        tv[3]  = '{0, 2, 'h10, 2, 'h10, 0, 0, 1, 0};
        tv[4]  = '{0, 2, 'h10, 2, 'h11, 1, 1, 1, 0};
        tv[5]  = '{0, 2, 'h10, 2, 'h11, 0, 1, 1, 0};
        tv[6]  = '{0, 2, 'h10, 2, 'h11, 0, 1, 1, 0};
        tv[7]  = '{0, 2, 'h10, 2, 'h12, 1, 2, 1, 0};
        tv[8]  = '{0, 2, 'h10, 2, 'h12, 0, 2, 1, 0};
        tv[9]  = '{0, 2, 'h10, 2, 'h12, 0, 2, 1, 0};
        tv[10] = '{0, 2, 'h10, 2, 'h13, 1, 3, 1, 0};
        tv[11] = '{0, 2, 'h10, 2, 'h13, 0, 3, 1, 0};
        tv[12] = '{0, 2, 'h10, 2, 'h13, 0, 3, 1, 0};
        tv[13] = '{0, 2, 'h10, 3, 'h14, 1, 3, 1, 1};
        tv[14] = '{0, 2, 'h10, 0, 'h14, 0, 3, 0, 0};
        tv[15] = '{0, 2, 'h10, 0, 'h14, 0, 3, 0, 0};

        // reset state
        doReset();
        chk("rst_state", 32'(stA), 32'd0);
        chk("rst_out1", outA, 32'd0);
        chk("rst_valid", 32'(validA), 32'd0);
        chk("rst_idx", 32'(idxA), 32'd0);
        chk("rst_busy", 32'(busyA), 32'd0);
        chk("rst_done", 32'(doneA), 32'd0);

        // basic pass
        for (int i = 0; i < 16; i++) begin
            start = tv[i].start[0];
            dwell = tv[i].dwell[7:0];
            in1   = tv[i].in1;
            tick();
            chk($sformatf("t1_state[%0d]", i), 32'(stA), tv[i].st);
            chk($sformatf("t1_out1[%0d]", i), outA, tv[i].o);
            chk($sformatf("t1_valid[%0d]", i), 32'(validA), tv[i].v);
            chk($sformatf("t1_idx[%0d]", i), 32'(idxA), tv[i].idx);
            chk($sformatf("t1_busy[%0d]", i), 32'(busyA), tv[i].b);
            chk($sformatf("t1_done[%0d]", i), 32'(doneA), tv[i].d);
        end

        // wrap with zero dwell, two steps
        doReset();
        dwell = 8'd0;
        in1   = 32'hFFFF_FFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t2_valid_c2", 32'(validB), 32'd0);
        chk("t2_state_c2", 32'(stB), 32'd2);
        tick();
        chk("t2_valid_c3", 32'(validB), 32'd1);
        chk("t2_out1_c3", outB, 32'h0000_0000);
        chk("t2_idx_c3", 32'(idxB), 32'd1);
        chk("t2_done_c3", 32'(doneB), 32'd0);
        tick();
        chk("t2_valid_c4", 32'(validB), 32'd1);
        chk("t2_out1_c4", outB, 32'h0000_0001);
        chk("t2_done_c4", 32'(doneB), 32'd1);
        chk("t2_state_c4", 32'(stB), 32'd3);
        tick();
        chk("t2_done_c5", 32'(doneB), 32'd0);
        chk("t2_busy_c5", 32'(busyB), 32'd0);
        chk("t2_state_c5", 32'(stB), 32'd0);

        // loop mode recaptures in1
        doReset();
        dwell  = 8'd2;
        in1    = 32'h10;
        loopEn = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tickTo(14);
        chk("t3_state_c14", 32'(stA), 32'd3);
        chk("t3_done_c14", 32'(doneA), 32'd1);
        in1 = 32'h40;
        while (cyc < 19) begin
            tick();
            chk($sformatf("t3_busy_c%0d", cyc), 32'(busyA), 32'd1);
            if (cyc == 15) chk("t3_state_c15", 32'(stA), 32'd1);
            if (cyc == 16) chk("t3_out1_c16", outA, 32'h40);
            if (cyc < 19) chk($sformatf("t3_valid_c%0d", cyc), 32'(validA), 32'd0);
        end
        chk("t3_valid_c19", 32'(validA), 32'd1);
        chk("t3_out1_c19", outA, 32'h41);
        abort  = 1'b1;
        loopEn = 1'b0;
        tick();
        abort = 1'b0;
        chk("t3_abort_state", 32'(stA), 32'd0);

        // abort coinciding with a step event
        doReset();
        dwell = 8'd2;
        in1   = 32'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        doneSeen = 0;
        while (cyc < 7) begin
            tick();
            if (doneA) doneSeen = 1;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_state", 32'(stA), 32'd0);
        chk("t4_valid", 32'(validA), 32'd0);
        chk("t4_out1", outA, 32'h11);
        chk("t4_idx", 32'(idxA), 32'd1);
        chk("t4_busy", 32'(busyA), 32'd0);
        while (cyc < 12) begin
            tick();
            if (doneA) doneSeen = 1;
        end
        chk("t4_done_never", 32'(doneSeen), 32'd0);
        chk("t4_out1_hold", outA, 32'h11);
        chk("t4_state_hold", 32'(stA), 32'd0);

        // reset mid-pass, then a fresh start
        doReset();
        dwell = 8'd2;
        in1   = 32'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        tickTo(9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_state", 32'(stA), 32'd0);
        chk("t5_out1", outA, 32'd0);
        chk("t5_valid", 32'(validA), 32'd0);
        chk("t5_idx", 32'(idxA), 32'd0);
        chk("t5_busy", 32'(busyA), 32'd0);
        chk("t5_done", 32'(doneA), 32'd0);
        tickTo(12);
        start = 1'b1;
        tick();
        start = 1'b0;
        firstValid = -1;
        while (cyc < 30 && firstValid < 0) begin
            tick();
            if (validA) firstValid = cyc;
        end
        chk("t5_first_valid_cycle", 32'(firstValid), 32'd17);
        chk("t5_first_out1", outA, 32'h11);

        // start with abort in IDLE
        doReset();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t6_contention_state", 32'(stA), 32'd0);
        chk("t6_contention_busy", 32'(busyA), 32'd0);
        tick();
        chk("t6_contention_state2", 32'(stA), 32'd0);

        // re-start and dwell/in1 changes mid-run are ignored until next START
        doReset();
        dwell = 8'd2;
        in1   = 32'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        mask = '0;
        while (cyc < 31) begin
            if (cyc == 3) begin
                start = 1'b1;
                dwell = 8'd7;
                in1   = 32'h99;
            end
            if (cyc == 4) start = 1'b0;
            if (cyc == 6) start = 1'b1;
            if (cyc == 7) start = 1'b0;
            if (cyc == 16) start = 1'b1;
            if (cyc == 17) start = 1'b0;
            tick();
            if (validA) mask[cyc] = 1'b1;
            if (cyc == 15) begin
                chk("t6_pass1_out1", outA, 32'h14);
                chk("t6_pass1_state", 32'(stA), 32'd0);
            end
            if (cyc == 26) chk("t6_pass2_out1", outA, 32'h9A);
        end
        expMask = (32'd1 << 5) | (32'd1 << 8) | (32'd1 << 11) | (32'd1 << 14) | (32'd1 << 26);
        chk("t6_valid_cycles", mask, expMask);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_step_fsm.md
Name: seq_step_fsm

Overview:
Parametrised step sequencer, the next generation of the team's demo start/end state machine.
- Captures an input word, then steps through NUM_STEPS programmable-dwell steps, adding STEP_INC to the word at each step.
- Flags each update with out_valid.
- Runs one-shot, or loops back and recaptures when loop_en is set.
- Used as a reusable control/pattern-generation core behind simple register-driven blocks.

Parameters:
DATA_W, 32, width of in1/out1
NUM_STEPS, 4, steps per pass (>=1)
DWELL_W, 8, width of dwell count
STEP_INC, 1, value added to out1 per step (truncated to DATA_W)

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a pass; sampled only in IDLE
abort  in  1  return to IDLE from any state; priority over everything except rst
loop_en  in  1  sampled in END: 1 = restart pass, 0 = IDLE
dwell  in  DWELL_W  extra cycles per step; latched in START
in1  in  DATA_W  seed value; captured in START
out1  out  DATA_W  current sequence value
out_valid  out  1  one-cycle pulse; out1 updated this cycle
step_idx  out  max(1,$clog2(NUM_STEPS))  index of the step in progress
busy  out  1  state != IDLE
done  out  1  high exactly while in END
fsm_state  out  8  encoded state: IDLE=0, START=1, RUN=2, END=3

Behaviour:
- Single clock domain; every output is registered.
- Reset (rst=1 at an edge): next cycle fsm_state=IDLE. out1, out_valid, step_idx, busy, done and the internal dwell counter all become 0. Reset mid-pass has the same effect.
- IDLE: start=1 and abort=0 -> START; otherwise stay IDLE.
- START (1 cycle):
  - out1<=in1; cnt<=dwell; step_idx<=0.
  - Next state RUN.
  - No out_valid.
- RUN, cnt!=0: cnt<=cnt-1.
- RUN, cnt==0 (step event):
  - Next cycle: out1<=out1+STEP_INC, modulo 2^DATA_W (wrap, no saturation), and out_valid=1.
  - If step_idx==NUM_STEPS-1 -> END and step_idx is held.
  - Otherwise step_idx<=step_idx+1 and cnt<=dwell_latched.
- END (1 cycle): done=1; loop_en=1 -> START (recaptures in1 and dwell); loop_en=0 -> IDLE.
- abort=1 in START, RUN or END:
  - Next state IDLE; busy=0 next cycle.
  - Any step event in the same cycle is suppressed: no out_valid, out1 holds.
  - out1 and step_idx keep their last values in IDLE.
- Ignored inputs: start outside IDLE; changes to dwell/in1 during RUN.
- dwell=0: one step per RUN cycle.
- Timing, with start seen in IDLE at cycle 0:
  - START at cycle 1.
  - Step events at 1+k*(dwell+1), k=1..NUM_STEPS.
  - out_valid one cycle after each step event.
  - END at 2+NUM_STEPS*(dwell+1); this coincides with the last out_valid.
  - busy falls the cycle after END when not looping.
- Simultaneous rst and abort: rst wins; result is identical.

Decomposition:
- Package seq_step_fsm_pkg holds:
  - state encoding constants IDLE/START/RUN/END as 8-bit values;
  - the state width;
  - a helper function for the step_idx width.
- Sub-module dwell_counter: DWELL_W-bit load/decrement counter with a zero flag.
  - Inputs: clk, rst, load, load_val, en.
  - Output: zero.
- Everything else lives in the top-level FSM.

Test Plan:
1. Basic pass. NUM_STEPS=4, STEP_INC=1, dwell=2, in1=0x10, loop_en=0, start pulse at cycle 0 -> out_valid at cycles 5, 8, 11, 14 with out1=0x11, 0x12, 0x13, 0x14; done=1 at cycle 14 only; busy=0 from cycle 15.
2. Wrap, minimum dwell. NUM_STEPS=2, dwell=0, in1=0xFFFFFFFF -> out_valid at cycles 3 and 4 with out1=0x00000000, then 0x00000001; done at 4.
3. Loop mode. Setup of test 1 with loop_en=1; in1 changed to 0x40 before cycle 15 -> START at 15, RUN resumes, out_valid at cycle 19 with out1=0x41; no IDLE in between.
4. Abort on step event. Setup of test 1, abort=1 at cycle 7 -> fsm_state=IDLE at 8, no out_valid at 8, out1 stays 0x11, step_idx=1, done never asserted.
5. Reset mid-pass. Setup of test 1, rst=1 at cycle 9 -> at cycle 10 all outputs 0 and fsm_state=0; a new start at cycle 12 gives its first out_valid at cycle 17.
6. Contention and latching.
   - start=1 and abort=1 together in IDLE -> stays IDLE.
   - start re-pulsed during RUN -> ignored, sequence timing unchanged.
   - dwell changed during RUN -> spacing unchanged until the next START.
